alu_sequencer: RTL

//   Issuing side of the combinational ALU's function interface. Accepts one

---
 rtl/alu_sequencer_if.sv | 30 +++
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between decode/control logic and the ALU sequencer.
// The master modport is the requester side and the slave modport is the sequencer side.
interface alu_sequencer_if #(
  parameter int WIDTH      = 32,
  parameter int FUNC_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [FUNC_WIDTH-1:0] req_op;
  logic [WIDTH-1:0]      req_a;
  logic [WIDTH-1:0]      req_b;
  logic                  req_ci;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_co;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_co, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_co, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issues one request at a time to a combinational ALU and waits a per-class latency.
// It then returns the captured sum, carry and flags over a valid/ready response channel.
module alu_sequencer #(
  parameter int WIDTH      = 32,
  parameter int FUNC_WIDTH = 5,
  parameter int FAST_LAT   = 1,
  parameter int SLOW_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.slave        bus,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic                  alu_ci,
  output logic [FUNC_WIDTH-1:0] alu_f,
  input  logic [WIDTH-1:0]      alu_s,
  input  logic                  alu_co
);

  localparam int LAT_MAX = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [FUNC_WIDTH-1:0] OP_NOOP = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] OP_MUL  = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] OP_DIV  = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] OP_MOD  = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] OP_LAST = FUNC_WIDTH'(22);

  localparam logic [CNT_W-1:0] FAST_CNT = CNT_W'(FAST_LAT - 1);
  localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(SLOW_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_is_err(input logic [FUNC_WIDTH-1:0] op, input logic [WIDTH-1:0] b);
    return (op > OP_LAST) || (((op == OP_DIV) || (op == OP_MOD)) && (b == '0));
  endfunction

  function automatic logic op_is_slow(input logic [FUNC_WIDTH-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_ready_r;
  logic             busy_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             rsp_co_r;
  logic             rsp_zero_r;
  logic             rsp_err_r;
  logic             req_err_s;
  logic             req_slow_s;

  assign req_err_s  = op_is_err(bus.req_op, bus.req_b);
  assign req_slow_s = op_is_slow(bus.req_op);

  // Sequencer FSM: accept, count down the execute latency, hold the response until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= '0;
      rsp_co_r     <= 1'b0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ci       <= 1'b0;
      alu_f        <= OP_NOOP;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            alu_a       <= bus.req_a;
            alu_b       <= bus.req_b;
            alu_ci      <= bus.req_ci;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            // Rejected ops never reach the ALU function input
            if (req_err_s) begin
              state_r      <= RESP;
              rsp_valid_r  <= 1'b1;
              rsp_result_r <= '0;
              rsp_co_r     <= 1'b0;
              rsp_zero_r   <= 1'b1;
              rsp_err_r    <= 1'b1;
            end else begin
              state_r <= EXEC;
              alu_f   <= bus.req_op;
              cnt_r   <= req_slow_s ? SLOW_CNT : FAST_CNT;
            end
          end
        end
        EXEC: begin
          if (cnt_r == '0) begin
            state_r      <= RESP;
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= alu_s;
            rsp_co_r     <= alu_co;
            rsp_zero_r   <= (alu_s == '0);
            rsp_err_r    <= 1'b0;
            alu_f        <= OP_NOOP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          alu_f       <= OP_NOOP;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.busy       = busy_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_co     = rsp_co_r;
  assign bus.rsp_zero   = rsp_zero_r;
  assign bus.rsp_err    = rsp_err_r;

endmodule
